// File: rtl/word_stream_checker.sv
// Hardware stream checker: skips a header, checks body words against an arithmetic progression
// with wrap, and (with WORD_STREAM_CHECKER_CHECKSUM_EN) verifies a trailing Fletcher checksum.
module word_stream_checker #(
    parameter int Width      = 16,
    parameter int CountWidth = 32,
    parameter bit Swap       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CountWidth-1:0] cfg_header_count,
    input  logic [CountWidth-1:0] cfg_body_count,
    input  logic [Width-1:0]      cfg_initial,
    input  logic                  cfg_delta_en,
    input  logic [Width-1:0]      cfg_delta,
    input  logic                  din_valid,
    input  logic [Width-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  ok,
    output logic                  err_word,
    output logic                  err_checksum,
    output logic [CountWidth-1:0] err_index,
    output logic [Width-1:0]      err_expected,
    output logic [Width-1:0]      err_got
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_BODY, S_CK_LO, S_CK_HI, S_DONE
    } state_t;

    localparam logic [Width-1:0] AllOnes = '1;
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
    localparam state_t AfterBody = S_CK_LO;
`else
    localparam state_t AfterBody = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [CountWidth-1:0] hdr_cnt_q, body_cnt_q, cnt_q, cnt_d;
    logic [Width-1:0]      initial_q, delta_q, prev_q, prev_d;
    logic                  delta_en_q;
    logic                  busy_q, busy_d, done_q, done_d, ok_q, ok_d;
    logic                  err_word_q, err_word_d;
    logic [CountWidth-1:0] err_index_q, err_index_d;
    logic [Width-1:0]      err_expected_q, err_expected_d, err_got_q, err_got_d;
    logic [Width-1:0]      x, exp_word;
    logic                  accept, last_word;

    always_comb begin
        x = din;
        if (Swap) begin
            for (int i = 0; i < Width / 8; i++) begin
                x[8*i +: 8] = din[Width-8-8*i +: 8];
            end
        end
    end

    assign accept = din_valid && !start &&
                    (state_q inside {S_HEADER, S_BODY, S_CK_LO, S_CK_HI});
    assign last_word = (state_q == S_HEADER) ? (cnt_q == hdr_cnt_q - CountWidth'(1))
                                             : (cnt_q == body_cnt_q - CountWidth'(1));

    // Progression restarts from the initial value when it would step past either end.
    always_comb begin
        if (cnt_q == '0 ||
            (prev_q == AllOnes && !delta_q[Width-1] && delta_q != '0) ||
            (prev_q == '0 && delta_q[Width-1])) begin
            exp_word = initial_q;
        end else begin
            exp_word = prev_q + delta_q;
        end
    end

`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
    logic [Width-1:0] sum_a_q, sum_a_d, sum_b_q, sum_b_d, a_rx_q, a_rx_d, a_new;
    logic             err_ck_q, err_ck_d;

    // Ones'-complement add: end-around carry, with all-ones folded to zero.
    function automatic logic [Width-1:0] mod_add(input logic [Width-1:0] p, input logic [Width-1:0] q);
        logic [Width:0]   s;
        logic [Width-1:0] f;
        s = {1'b0, p} + {1'b0, q};
        f = s[Width-1:0] + Width'(s[Width]);
        return (f == AllOnes) ? '0 : f;
    endfunction

    assign a_new = mod_add(sum_a_q, x);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start) begin
            if (cfg_header_count != '0) begin
                state_d = S_HEADER;
            end else if (cfg_body_count != '0) begin
                state_d = S_BODY;
            end else begin
                state_d = AfterBody;
            end
        end else if (accept) begin
            case (state_q)
                S_HEADER: if (last_word) state_d = (body_cnt_q != '0) ? S_BODY : AfterBody;
                S_BODY:   if (last_word) state_d = AfterBody;
                S_CK_LO:  state_d = S_CK_HI;
                S_CK_HI:  state_d = S_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        cnt_d          = cnt_q;
        prev_d         = prev_q;
        err_word_d     = err_word_q;
        err_index_d    = err_index_q;
        err_expected_d = err_expected_q;
        err_got_d      = err_got_q;
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
        sum_a_d  = sum_a_q;
        sum_b_d  = sum_b_q;
        a_rx_d   = a_rx_q;
        err_ck_d = err_ck_q;
`endif
        if (start) begin
            cnt_d          = '0;
            prev_d         = '0;
            err_word_d     = 1'b0;
            err_index_d    = '0;
            err_expected_d = '0;
            err_got_d      = '0;
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
            sum_a_d  = '0;
            sum_b_d  = '0;
            a_rx_d   = '0;
            err_ck_d = 1'b0;
`endif
        end else if (accept) begin
            cnt_d = (state_d != state_q) ? '0 : cnt_q + CountWidth'(1);
            if (state_q == S_BODY) begin
                prev_d = x;
                if (delta_en_q && x != exp_word) begin
                    err_word_d = 1'b1;
                    if (!err_word_q) begin
                        err_index_d    = cnt_q;
                        err_expected_d = exp_word;
                        err_got_d      = x;
                    end
                end
            end
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
            if (state_q == S_HEADER || state_q == S_BODY) begin
                sum_a_d = a_new;
                sum_b_d = mod_add(sum_b_q, a_new);
            end
            if (state_q == S_CK_LO) begin
                a_rx_d = x;
            end
            if (state_q == S_CK_HI && {x, a_rx_q} != {sum_b_q, sum_a_q}) begin
                err_ck_d = 1'b1;
            end
`endif
        end
        busy_d = state_d inside {S_HEADER, S_BODY, S_CK_LO, S_CK_HI};
        done_d = (state_d == S_DONE);
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
        ok_d = done_d && !err_word_d && !err_ck_d;
`else
        ok_d = done_d && !err_word_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_cnt_q      <= '0;
            body_cnt_q     <= '0;
            initial_q      <= '0;
            delta_q        <= '0;
            delta_en_q     <= 1'b0;
            cnt_q          <= '0;
            prev_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ok_q           <= 1'b0;
            err_word_q     <= 1'b0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_got_q      <= '0;
        end else begin
            if (start) begin
                hdr_cnt_q  <= cfg_header_count;
                body_cnt_q <= cfg_body_count;
                initial_q  <= cfg_initial;
                delta_q    <= cfg_delta;
                delta_en_q <= cfg_delta_en;
            end
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            ok_q           <= ok_d;
            err_word_q     <= err_word_d;
            err_index_q    <= err_index_d;
            err_expected_q <= err_expected_d;
            err_got_q      <= err_got_d;
        end
    end

`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_a_q  <= '0;
            sum_b_q  <= '0;
            a_rx_q   <= '0;
            err_ck_q <= 1'b0;
        end else begin
            sum_a_q  <= sum_a_d;
            sum_b_q  <= sum_b_d;
            a_rx_q   <= a_rx_d;
            err_ck_q <= err_ck_d;
        end
    end
    assign err_checksum = err_ck_q;
`else
    assign err_checksum = 1'b0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign ok           = ok_q;
    assign err_word     = err_word_q;
    assign err_index    = err_index_q;
    assign err_expected = err_expected_q;
    assign err_got      = err_got_q;

endmodule

// File: tb/tb_word_stream_checker.sv
// Bench for word_stream_checker: stream-position model compared every cycle, plus literal pins.
module tb_word_stream_checker;
    localparam int W  = 16;
    localparam int CW = 32;
    localparam longint M = (64'd1 << W) - 1;
`ifdef WORD_STREAM_CHECKER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [W-1:0] wq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_header_count = '0, cfg_body_count = '0;
    logic [W-1:0]  cfg_initial = '0, cfg_delta = '0;
    logic          cfg_delta_en = 1'b0;
    logic          din_valid = 1'b0;
    logic [W-1:0]  din = '0;
    logic          busy, done, ok, err_word, err_checksum;
    logic [CW-1:0] err_index;
    logic [W-1:0]  err_expected, err_got;

    always #5 clk = ~clk;

    word_stream_checker #(.Width(W), .CountWidth(CW), .Swap(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_header_count(cfg_header_count), .cfg_body_count(cfg_body_count),
        .cfg_initial(cfg_initial), .cfg_delta_en(cfg_delta_en), .cfg_delta(cfg_delta),
        .din_valid(din_valid), .din(din),
        .busy(busy), .done(done), .ok(ok), .err_word(err_word), .err_checksum(err_checksum),
        .err_index(err_index), .err_expected(err_expected), .err_got(err_got)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] bswap(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) r[8*i +: 8] = v[W-8-8*i +: 8];
        return r;
    endfunction

    // Fletcher over host-order words, plain modular arithmetic; returns {B, A}.
    function automatic logic [31:0] fletcher(input wq_t xs);
        longint a = 0, b = 0;
        foreach (xs[i]) begin
            a = (a + longint'(xs[i])) % M;
            b = (b + a) % M;
        end
        return {16'(b), 16'(a)};
    endfunction

    // Model: tracks position in the expected stream rather than any state machine.
    bit           m_armed = 0, m_errw = 0, m_errc = 0;
    longint       m_pos = 0, m_total = 0, m_h = 0, m_b = 0, m_a = 0, m_bs = 0;
    logic [W-1:0] m_init = '0, m_delta = '0, m_prev = '0, m_arx = '0, m_exp = '0, m_got = '0;
    logic [CW-1:0] m_idx = '0;
    bit           m_den = 0;

    always @(posedge clk) begin
        logic [W-1:0] xv, e;
        longint i;
        if (!rst_n) begin
            m_armed = 0; m_errw = 0; m_errc = 0; m_pos = 0; m_total = 0;
            m_idx = '0; m_exp = '0; m_got = '0;
        end else if (start) begin
            m_armed = 1; m_errw = 0; m_errc = 0; m_pos = 0;
            m_h = longint'(cfg_header_count); m_b = longint'(cfg_body_count);
            m_total = m_h + m_b + (CK ? 2 : 0);
            m_init = cfg_initial; m_delta = cfg_delta; m_den = cfg_delta_en;
            m_a = 0; m_bs = 0; m_idx = '0; m_exp = '0; m_got = '0;
        end else if (din_valid && m_armed && m_pos < m_total) begin
            xv = bswap(din);
            if (m_pos < m_h + m_b) begin
                m_a = (m_a + longint'(xv)) % M;
                m_bs = (m_bs + m_a) % M;
                if (m_pos >= m_h) begin
                    i = m_pos - m_h;
                    if (i == 0 || (m_prev == '1 && $signed(m_delta) > 0) ||
                        (m_prev == '0 && $signed(m_delta) < 0))
                        e = m_init;
                    else
                        e = m_prev + m_delta;
                    if (m_den && xv != e) begin
                        if (!m_errw) begin
                            m_idx = CW'(i); m_exp = e; m_got = xv;
                        end
                        m_errw = 1;
                    end
                    m_prev = xv;
                end
            end else if (m_pos == m_h + m_b) begin
                m_arx = xv;
            end else if (longint'(xv) != m_bs || longint'(m_arx) != m_a) begin
                m_errc = 1;
            end
            m_pos++;
        end
    end

    always @(negedge clk) begin
        bit mdone;
        mdone = m_armed && (m_pos == m_total);
        check("busy", busy, m_armed && (m_pos < m_total));
        check("done", done, mdone);
        check("ok", ok, mdone && !m_errw && !m_errc);
        check("err_word", err_word, m_errw);
        check("err_checksum", err_checksum, m_errc);
        check("err_index", err_index, m_idx);
        check("err_expected", err_expected, m_exp);
        check("err_got", err_got, m_got);
    end

    task automatic cyc(input bit s, input bit v, input logic [W-1:0] d);
        @(negedge clk);
        start = s; din_valid = v; din = d;
    endtask

    task automatic arm(input int h, input int b, input logic [W-1:0] init,
                       input logic [W-1:0] dl, input bit den, input bit with_word);
        cfg_header_count = CW'(h); cfg_body_count = CW'(b);
        cfg_initial = init; cfg_delta = dl; cfg_delta_en = den;
        cyc(1'b1, with_word, 16'hDEAD);
    endtask

    // Sends host-order words byte-swapped (little-endian on the wire), then idles one cycle.
    task automatic send(input wq_t xs);
        foreach (xs[i]) cyc(1'b0, 1'b1, bswap(xs[i]));
        cyc(1'b0, 1'b0, '0);
    endtask

    function automatic wq_t with_ck(input wq_t xs, input logic [W-1:0] hi_adj);
        logic [31:0] f;
        wq_t r;
        f = fletcher(xs);
        r = xs;
        r.push_back(f[15:0]);
        r.push_back(f[31:16] + hi_adj);
        return r;
    endfunction

    initial begin
        wq_t base, bad, s;
        logic [31:0] f;
        base = '{16'h3412, 16'h7856, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err_index", err_index, 0);

        // Model pin: hand-computed Fletcher of the basic stream.
        f = fletcher(base);
        check("fletcher_pin", f, 32'h9231_AC72);

        // 1: clean stream
        arm(2, 4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        send(with_ck(base, 16'h0));
        check("t1_done", done, 1);
        check("t1_ok", ok, 1);
        check("t1_err_word", err_word, 0);

        // 2: third body word corrupted
        bad = base;
        bad[4] = 16'h0009;
        arm(2, 4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        send(with_ck(bad, 16'h0));
        check("t2_err_word", err_word, 1);
        check("t2_err_index", err_index, 2);
        check("t2_err_expected", err_expected, 16'h0003);
        check("t2_err_got", err_got, 16'h0009);
        check("t2_ok", ok, 0);
        check("t2_done", done, 1);

        // 3: upward wrap back to the initial value
        s = '{16'hFFFE, 16'hFFFF, 16'hFFFE};
        arm(0, 3, 16'hFFFE, 16'h0001, 1'b1, 1'b0);
        send(with_ck(s, 16'h0));
        check("t3_ok", ok, 1);

        // 3b: downward wrap with delta -1
        s = '{16'h0001, 16'h0000, 16'h0001};
        arm(0, 3, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        send(with_ck(s, 16'h0));
        check("t3b_ok", ok, 1);

        // 3c: progression check disabled, arbitrary body
        s = '{16'h1111, 16'h5A5A, 16'h0000};
        arm(1, 2, 16'h0000, 16'h0001, 1'b0, 1'b0);
        send(with_ck(s, 16'h0));
        check("t3c_ok", ok, 1);

        // 4: checksum high word off by one
        arm(2, 4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        send(with_ck(base, 16'h1));
        check("t4_err_checksum", err_checksum, CK);
        check("t4_err_word", err_word, 0);
        check("t4_ok", ok, !CK);

        // 5: reset mid-body, then start coincident with a dropped word
        arm(2, 4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, bswap(base[i]));
        @(negedge clk);
        din_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        arm(2, 4, 16'h0001, 16'h0001, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, '0);
        check("t5_busy", busy, 1);
        send(with_ck(base, 16'h0));
        check("t5_ok", ok, 1);

        // 6: empty header and body
        arm(0, 0, 16'h0000, 16'h0001, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0);
        check("t6_done_early", done, !CK);
        check("t6_busy", busy, CK);
        s = '{16'h0000, 16'h0000};
        send(s);
        check("t6_ok", ok, 1);

        // Words after completion are ignored.
        send(s);
        check("t7_done_hold", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
